// File: rtl/mega_div_seq.sv
// mega_div_seq: iterative restoring divider, signed/unsigned, start/busy/done handshake.
module mega_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] a, b, p;
    logic [WIDTH:0] p_shift;
    logic ge, neg_q, neg_r;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = !start ? IDLE : (divisor == '0 ? ZERO : RUN);
            RUN: state_nxt = count == CW'(WIDTH - 1) ? FIX : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    assign p_shift = {p, a[WIDTH-1]};
    assign ge = p_shift >= {1'b0, b};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {a, b, p, count, neg_q, neg_r} <= '0;
            {quotient, remainder, div_zero, done} <= '0;
        end else begin
            done <= state == FIX || state == ZERO;
            case (state)
                IDLE: if (start) begin
                    // a holds the raw dividend on the zero path so ZERO can return it unmodified
                    a <= divisor == '0 ? dividend : (signed_op && dividend[WIDTH-1] ? -dividend : dividend);
                    b <= signed_op && divisor[WIDTH-1] ? -divisor : divisor;
                    neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= signed_op && dividend[WIDTH-1];
                    p <= '0;
                    count <= '0;
                end
                RUN: begin
                    p <= ge ? WIDTH'(p_shift - {1'b0, b}) : p_shift[WIDTH-1:0];
                    a <= {a[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    quotient <= neg_q ? -a : a;
                    remainder <= neg_r ? -p : p;
                    div_zero <= 1'b0;
                end
                default: begin
                    quotient <= '1;
                    remainder <= a;
                    div_zero <= 1'b1;
                end
            endcase
        end
endmodule

// File: doc/mega_div_seq.md
# mega_div_seq

Iterative restoring integer divider: the inverse companion of the ALU's multiply instructions. The AVR ALU has no divide instruction, so this block sits beside it as a memory-mapped arithmetic peripheral behind the I/O bus glue. It takes a dividend and divisor, in signed or unsigned mode, and returns quotient and remainder after a fixed number of cycles. The handshake is start/busy/done.

## Interface

Parameters:
- WIDTH, 16: operand and result width in bits; legal values are 8 and 16.

Ports:
- clk, input, 1: core clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a division; sampled only in IDLE.
- signed_op, input, 1: 1 selects two's-complement operands and results; 0 selects unsigned; sampled with start.
- dividend, input, WIDTH: numerator; sampled with start.
- divisor, input, WIDTH: denominator; sampled with start.
- busy, output, 1: high from the edge that accepts start until the edge that raises done.
- done, output, 1: one-cycle pulse; results are valid from this cycle on.
- quotient, output, WIDTH: registered quotient; held until the next done.
- remainder, output, WIDTH: registered remainder; held until the next done.
- div_zero, output, 1: registered; set with done when divisor was 0, cleared with the next done otherwise.

## Operation

States:
- IDLE
  - start=1 with divisor≠0: latch the magnitudes of both operands, latch the negative-quotient flag (signed_op & (dividend[MSB]^divisor[MSB])) and the negative-remainder flag (signed_op & dividend[MSB]). Clear the partial remainder, set count=0, go to RUN.
  - start=1 with divisor=0: go to ZERO.
- RUN
  - One restoring step per cycle: partial remainder P (WIDTH+1 bits) = {P[WIDTH-1:0], A[MSB]}; A <<= 1.
  - If P ≥ |divisor|: P -= |divisor| and A[0] = 1.
  - count increments each step; after the step with count=WIDTH-1, go to FIX.
- FIX
  - quotient = A, negated if the negative-quotient flag is set.
  - remainder = P[WIDTH-1:0], negated if the negative-remainder flag is set.
  - Pulse done, clear div_zero, go to IDLE.
- ZERO
  - quotient = all ones, remainder = dividend (raw, unmodified), div_zero=1, pulse done, go to IDLE.

Arithmetic rules:
- Magnitude of a negative operand is the two's complement, taken modulo 2^WIDTH. For example, |0x8000| = 0x8000 and is treated as unsigned.
- Signed results truncate toward zero. The remainder carries the sign of the dividend.
- Signed overflow (most-negative / -1) yields quotient = most-negative and remainder 0. No flag is raised.
- start while busy is ignored. There is no queueing and operands are not resampled.
- Operands may change freely after the accepting edge.

## Timing

- Reset (asynchronous, rst_n low): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, all internal registers 0. Reset takes effect immediately, including mid-operation; the in-flight result is discarded.
- Normal division, start accepted at edge E0:
  - busy=1 after E0.
  - RUN occupies edges E1..E_WIDTH.
  - FIX at edge E_WIDTH+1 sets done=1 and busy=0.
  - Latency is WIDTH+1 cycles (17 for WIDTH=16).
- Divide by zero: done=1 after E1; latency 1 cycle.
- done is high for exactly one cycle.
- A new start may be sampled in the same cycle that done is high, because the state is already IDLE. It is accepted on the next edge.
- Outputs change only on the edge that raises done, or on reset.

## Test plan

- Unsigned 16-bit: 1000/7 -> done 17 cycles after the accepting edge; quotient=0x008E (142), remainder=0x0006, div_zero=0. busy is high for 17 cycles.
- Signed: -7/2 (0xFFF9/0x0002, signed_op=1) -> quotient=0xFFFD, remainder=0xFFFF.
- Signed: 7/-2 -> quotient=0xFFFD, remainder=0x0001.
- Same operands with signed_op=0: 0xFFF9/2 -> quotient=0x7FFC, remainder=0x0001.
- Signed overflow: 0x8000/0xFFFF, signed_op=1 -> quotient=0x8000, remainder=0x0000, div_zero=0.
- Divide by zero: 0x1234/0 -> done one cycle after the accepting edge; quotient=0xFFFF, remainder=0x1234, div_zero=1. A following 10/3 -> quotient=3, remainder=1, div_zero cleared.
- Protocol:
  - Start 1000/7, then pulse start with 50/5 at cycle 5 -> ignored; the result is still 142 r 6.
  - Assert rst_n low at cycle 8 of a division -> all outputs 0 immediately, and no done pulse occurs.
  - Back-to-back: start held high through done -> the second division is accepted on the edge after done, and its done arrives 17 cycles later.
